ex_alu_md: RTL

EX_ALU_MD -- requirements
Module: ex_alu_md

---
 rtl/ex_alu_md.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ex_alu_md.sv
// Execute-stage integer ALU with iterative multiply/divide unit.
// Simple ops finish in one cycle. MUL*/DIV* ops iterate XLEN cycles on operand magnitudes.
module ex_alu_md #(
    parameter int XLEN  = 32,
    parameter int TID_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TID_W-1:0] in_tid,
    input  logic [4:0]       in_rd_addr,
    input  logic             in_rd_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TID_W-1:0] out_tid,
    output logic [4:0]       out_rd_addr,
    output logic             out_rd_wen,
    output logic             busy,
    output logic [1:0]       fsm_state
);
    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. out_* hold
    // stable while out_valid is high and out_ready is low. flush overrides both.
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    localparam int SHW = $clog2(XLEN);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
    localparam logic [4:0] OP_DIVU = 5'd15,   OP_REM = 5'd16,   OP_REMU = 5'd17;

    state_t            state;
    logic [SHW-1:0]    cnt;
    logic [4:0]        op_q;
    logic [TID_W-1:0]  tid_q;
    logic [4:0]        rd_q;
    logic              wen_q;
    logic              neg_q, rneg_q;
    logic [XLEN-1:0]   hi, lo, md;

    assign in_ready  = (state == IDLE) && !flush;
    assign busy      = (state == MUL) || (state == DIV);
    assign fsm_state = state;

    // Single-cycle results, computed straight from the request ports.
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  sra_res, simple_res;
    always_comb begin
        shamt      = in_op2[SHW-1:0];
        sra_res    = $signed(in_op1) >>> shamt;
        simple_res = '0;
        case (in_op)
            OP_ADD:  simple_res = in_op1 + in_op2;
            OP_SUB:  simple_res = in_op1 - in_op2;
            OP_SLL:  simple_res = in_op1 << shamt;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
            OP_XOR:  simple_res = in_op1 ^ in_op2;
            OP_SRL:  simple_res = in_op1 >> shamt;
            OP_SRA:  simple_res = sra_res;
            OP_OR:   simple_res = in_op1 | in_op2;
            OP_AND:  simple_res = in_op1 & in_op2;
            default: simple_res = '0;
        endcase
    end

    logic             is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]  a_mag, b_mag, bypass_res;
    always_comb begin
        is_mul   = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
        is_div   = (in_op >= OP_DIV) && (in_op <= OP_REMU);
        a_sgn    = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                   (in_op == OP_DIV) || (in_op == OP_REM);
        b_sgn    = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
        a_neg    = a_sgn && in_op1[XLEN-1];
        b_neg    = b_sgn && in_op2[XLEN-1];
        a_mag    = a_neg ? -in_op1 : in_op1;
        b_mag    = b_neg ? -in_op2 : in_op2;
        div_zero = (in_op2 == '0);
        div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_op2);
        if (div_zero)
            bypass_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_op1;
        else
            bypass_res = (in_op == OP_DIV) ? in_op1 : '0;
    end

    // One iteration step; the final step's results feed the output register directly.
    logic [XLEN:0]      mul_sum, div_sh;
    logic               div_ok;
    logic [XLEN-1:0]    mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, quo, rem, mul_res, div_res;
    logic [2*XLEN-1:0]  prod, prod_s;
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};
        div_sh   = {hi, lo[XLEN-1]};
        div_ok   = (div_sh >= {1'b0, md});
        div_hi_n = div_ok ? (div_sh[XLEN-1:0] - md) : div_sh[XLEN-1:0];
        div_lo_n = {lo[XLEN-2:0], div_ok};
        prod     = {mul_hi_n, mul_lo_n};
        prod_s   = neg_q ? -prod : prod;
        mul_res  = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo      = neg_q ? -div_lo_n : div_lo_n;
        rem      = rneg_q ? -div_hi_n : div_hi_n;
        div_res  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;   cnt <= '0;       op_q <= '0;  tid_q <= '0;
            rd_q <= '0;      wen_q <= 1'b0;   neg_q <= 1'b0; rneg_q <= 1'b0;
            hi <= '0;        lo <= '0;        md <= '0;
            out_valid <= 1'b0; out_data <= '0; out_tid <= '0;
            out_rd_addr <= '0; out_rd_wen <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    op_q  <= in_op;
                    tid_q <= in_tid;
                    rd_q  <= in_rd_addr;
                    wen_q <= in_rd_wen;
                    cnt   <= '0;
                    if (is_mul) begin
                        hi <= '0; lo <= b_mag; md <= a_mag;
                        neg_q <= a_neg ^ b_neg;
                        state <= MUL;
                    end else if (is_div && !div_zero && !div_ovf) begin
                        hi <= '0; lo <= a_mag; md <= b_mag;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        state  <= DIV;
                    end else begin
                        out_data    <= is_div ? bypass_res : simple_res;
                        out_tid     <= in_tid;
                        out_rd_addr <= in_rd_addr;
                        out_rd_wen  <= (in_op <= OP_REMU) && in_rd_wen;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                MUL, DIV: begin
                    hi  <= (state == MUL) ? mul_hi_n : div_hi_n;
                    lo  <= (state == MUL) ? mul_lo_n : div_lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) begin
                        out_data    <= (state == MUL) ? mul_res : div_res;
                        out_tid     <= tid_q;
                        out_rd_addr <= rd_q;
                        out_rd_wen  <= wen_q;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
